// File: rtl/serial_pkg.sv
// Shared serial-link definitions: line states and line levels.
// Used by serial_tx and by the future serial receiver.
// No logic; types and constants only.
package serial_pkg;

  // Frame phases on the line; PARITY exists only when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, Tick at terminal count, then wraps.
// Latency: Tick is decoded from the count register, so it has no input path.
// Clear forces the count back to 0 on the next edge (used on every state change).
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With CLKS_PER_BIT=1 the count sits at 0 and every cycle is a tick.
  assign Tick = (cnt_q == TERMINAL);

  // Next count: wrap on tick, restart on clear, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (Clear || Tick) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Bit-serial transmitter: start bit, DATA_W bits LSB-first, [even parity], stop bit.
// Latency: Tx shows the start bit in the cycle right after the Load/Ready edge.
// Backpressure: Ready is low for the whole frame; Load while busy is dropped.
// Optional parity bit is enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data_in,
  input  logic              Load,
  output logic              Ready,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              tick;
  logic              clear;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // Restart the bit period whenever the frame moves to a new phase.
  assign clear = (state_d != state_q);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (clear),
    .Tick  (tick)
  );

  assign Ready = (state_q == IDLE);
  assign Busy  = ~Ready;
  assign Done  = (state_q == STOP) && tick;
  assign Tx    = tx_q;

  // Next-state, shift and line-level logic; Tx is computed from the next state
  // so the registered line level lines up with the phase it belongs to.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (Load) begin
          state_d = START;
          shreg_d = Data_in;
          idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^Data_in;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    tx_d = IDLE_LEVEL;
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  // State, datapath and line registers; reset drives the line idle at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      tx_q    <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx (DATA_W=8, CLKS_PER_BIT=4): table vectors, hand-written
// corner sequences and random frames checked against a frame-level model.
module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = DW + 2 + PAR;
  localparam int FRAME = NBITS * CPB;

  logic          Clk;
  logic          Reset;
  logic [DW-1:0] Data_in;
  logic          Load;
  logic          Ready;
  logic          Tx;
  logic          Busy;
  logic          Done;

  int checks = 0;
  int errors = 0;

  serial_tx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Data_in (Data_in),
    .Load    (Load),
    .Ready   (Ready),
    .Tx      (Tx),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] data;
    logic       par;      // expected even-parity bit (used in parity builds)
    bit         keep;     // hold Load high into the next frame
    bit         intrude;  // pulse Load with 8'hFF in the middle of the frame
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line bits of one frame, index 0 = start bit, one entry per bit period.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic p);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1 + i] = d[i];
    if (PAR == 1) b[DW + 1] = p;
    b[NBITS - 1] = 1'b1;
    return b;
  endfunction

  // Idle line: checked once per cycle, n cycles.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_idle_tx"}, Tx, 1'b1);
      check({tag, "_idle_ready"}, Ready, 1'b1);
      check({tag, "_idle_busy"}, Busy, 1'b0);
      check({tag, "_idle_done"}, Done, 1'b0);
      @(negedge Clk);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of the
  // first idle cycle after the frame, having checked that cycle.
  task automatic run_frame(input logic [7:0] d, input logic p, input bit keep,
                           input bit intrude, input string tag);
    logic [15:0] bits;
    bits = frame_bits(d, p);
    check({tag, "_pre_ready"}, Ready, 1'b1);
    Data_in = d;
    Load    = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    if (!keep) Load = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      check({tag, "_tx"}, Tx, bits[k / CPB]);
      check({tag, "_ready_low"}, Ready, 1'b0);
      check({tag, "_busy"}, Busy, 1'b1);
      check({tag, "_done"}, Done, (k == FRAME - 1) ? 1'b1 : 1'b0);
      if (intrude && k == 10) begin
        Data_in = 8'hFF;
        Load    = 1'b1;
      end else if (intrude && k == 12) begin
        Load = 1'b0;
      end else if (keep) begin
        Data_in = 8'($urandom);
      end
      @(negedge Clk);
    end
    check({tag, "_end_ready"}, Ready, 1'b1);
    check({tag, "_end_tx"}, Tx, 1'b1);
    check({tag, "_end_done"}, Done, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h81, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b0, 1'b0};

    // Reset held 3 cycles with Load asserted: line stays idle throughout.
    Reset   = 1'b1;
    Load    = 1'b1;
    Data_in = 8'hA5;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("rst_tx", Tx, 1'b1);
      check("rst_ready", Ready, 1'b1);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
    end
    Reset = 1'b0;
    Load  = 1'b0;
    @(negedge Clk);
    idle(2, "post_rst");

    // Table vectors: single frame, ignored load, back-to-back pair, parity value.
    for (int v = 0; v < 5; v++) begin
      run_frame(tbl[v].data, tbl[v].par, tbl[v].keep, tbl[v].intrude, $sformatf("vec%0d", v));
      if (!tbl[v].keep) begin
        Load = 1'b0;
        @(negedge Clk);
        idle(3, $sformatf("vec%0d", v));
      end
    end

    // Reset in the middle of data bit 3 (a 0 bit), then a clean frame.
    Data_in = 8'h52;
    Load    = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Load = 1'b0;
    repeat (17) @(negedge Clk);
    check("midrst_before_tx", Tx, 1'b0);
    #1;
    Reset = 1'b1;
    #1;
    check("midrst_tx", Tx, 1'b1);
    check("midrst_ready", Ready, 1'b1);
    check("midrst_done", Done, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("midrst_hold_done", Done, 1'b0);
      check("midrst_hold_tx", Tx, 1'b1);
    end
    Reset = 1'b0;
    @(negedge Clk);
    idle(3, "midrst_after");
    run_frame(8'h3C, ^8'h3C, 1'b0, 1'b0, "midrst_frame");
    @(negedge Clk);
    idle(2, "midrst_frame");

    // Random frames, randomly back-to-back or separated by idle gaps.
    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      bit keep;
      d    = 8'($urandom);
      keep = (r == 19) ? 1'b0 : bit'($urandom_range(0, 1));
      run_frame(d, ^d, keep, 1'b0, "rnd");
      if (!keep) begin
        Load = 1'b0;
        @(negedge Clk);
        idle($urandom_range(1, 3), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Bit-serial transmitter: accepts a parallel word through a valid/ready handshake and shifts it out on a single line as start bit, data LSB-first, and stop bit. It is the sending end of the board's single-wire serial link, which is captured on the far side by a clocked flip-flop/shift chain. On the DE2 it sits between switch/register sources and a GPIO pin (or loopback to the receiver lab).

Parameters:
DATA_W, 8, payload bits per frame (1..16)
CLKS_PER_BIT, 4, Clk cycles each bit is held on Tx (>=1)

Ports:
Clk  input  1  system clock, rising edge active
Reset  input  1  asynchronous, active-high; clears all state immediately
Data_in  input  DATA_W  word to send, sampled on handshake
Load  input  1  request: Data_in valid
Ready  output  1  high when idle and able to accept Load
Tx  output  1  serial line, idle high
Busy  output  1  high while a frame is on the line (= ~Ready)
Done  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Single clock Clk; Reset asynchronous, active-high.
- Reset values: Tx=1, Ready=1, Busy=0, Done=0, state IDLE, counters 0, shift reg 0.
- Handshake: transfer occurs on the rising edge where Load=1 and Ready=1. Data_in is latched into the shift register on that edge, and Ready drops the same edge.
- Load while Ready=0 is ignored (no queueing, no corruption of the current frame).
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: Tx=1. On handshake go to START.
- START: Tx=0 for CLKS_PER_BIT cycles.
- DATA: Tx = shreg[0]. Shift right every CLKS_PER_BIT cycles. Bit index counts 0..DATA_W-1; after the last bit go to STOP.
- STOP: Tx=1 for CLKS_PER_BIT cycles. Done=1 in the final cycle. Next edge goes to IDLE with Ready=1.
- Cycle timing: with the handshake at edge 0, the first start-bit cycle is edge 0..1. Frame length is (DATA_W+2)*CLKS_PER_BIT cycles. Ready rises at edge (DATA_W+2)*CLKS_PER_BIT.
- Back-to-back frames: Load held high gives a new handshake on the edge Ready returns. Minimum 1 idle cycle (Tx=1) between frames.
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps. It issues a tick at terminal count and resets to 0 on every state change. With CLKS_PER_BIT=1, every cycle is a tick.
- Reset mid-frame: Tx returns high asynchronously, the partial frame is abandoned, and no Done is issued.
- Outputs are registered, with no combinational path from Load/Data_in to Tx.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP. Tx = even parity (XOR of the latched word) for CLKS_PER_BIT cycles. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, and frame length is as above.

Decomposition:
- Package serial_pkg holds:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1;
  - shared with the future serial receiver.
- Sub-module bit_timer (param CLKS_PER_BIT): inputs Clk, Reset, Clear; output Tick. Instantiated once.

Test Plan:
- Reset/idle: assert Reset for 3 cycles with Load=1 -> Tx=1, Ready=1, Busy=0, Done=0 throughout.
- Single frame (DATA_W=8, CLKS_PER_BIT=4), Data_in=8'hA5 with a one-cycle Load:
  - Tx bit sequence, each bit held 4 cycles, is 0,1,0,1,0,0,1,0,1,1.
  - Ready is low for exactly 40 cycles.
  - Done pulses once in cycle 40.
- Ignored load: during the frame, pulse Load with Data_in=8'hFF -> frame bits unchanged (still 0xA5) and no second frame starts.
- Back-to-back: hold Load=1 with 8'h00 then 8'h81 -> two complete frames, Tx=1 for exactly 1 cycle between them, data bits 00000000 then 10000001.
- Mid-frame reset: assert Reset in data bit 3 -> Tx=1 in the same cycle, Ready=1 after release, no Done. The next Load of 8'h3C sends a correct frame.
- With SERIAL_TX_PARITY_EN defined:
  - 8'hA5 -> parity bit 0 inserted before stop, frame 44 cycles;
  - 8'h01 -> parity bit 1.
